usb_pll_ctrl: RTL and testbench
===============================

Name: usb_pll_ctrl

Overview:
Power-up and lock supervisor for the USB clock PLL (24 MHz in, clkout0/clkout1 out). Runs on the free-running 24 MHz reference clock. It drives the PLL RESET and PLLPWD pins, qualifies and debounces LOCK, retries failed acquisitions and recovers from loss of lock. It gives the USB clock domains a clean reset and a ready flag, and provides a suspend power-down handshake.

Parameters:
RST_CYCLES, 24, PLL RESET pulse width in clkin cycles (1 us)
LOCK_TIMEOUT, 24000, max cycles in WAIT_LOCK before retry (1 ms)
STABLE_CYCLES, 240, consecutive qualified-lock cycles required before RUN (10 us)
MAX_RETRY, 3, retries after first attempt before FAIL (≤7)

Ports:
clkin  input  1  24 MHz reference clock, sole clock
reset  input  1  synchronous, active-high
lock  input  1  PLL LOCK, asynchronous
suspend_req  input  1  level request to power PLL down
pll_reset  output  1  to PLL RESET
pll_pwd  output  1  to PLL PLLPWD
usb_rst  output  1  active-high reset for clkout0/clkout1 logic (resynchronised there)
pll_ready  output  1  PLL locked and qualified
suspend_ack  output  1  PLL is powered down
fail  output  1  acquisition abandoned
retry_cnt  output  3  retries used in current acquisition
loss_cnt  output  8  saturating count of lock losses in RUN

Behaviour:
- lock passes through a 2-flop synchroniser to lock_s. All decisions use lock_s. Synchroniser flops reset to 0.
- All outputs are registered Moore outputs of the state. One 16-bit cycle counter cnt is cleared on every state change.
- Reset values: state RST_PLL, cnt=0, pll_reset=1, pll_pwd=0, usb_rst=1, pll_ready=0, suspend_ack=0, fail=0, retry_cnt=0, loss_cnt=0.
- Reset asserted mid-operation, in any state: the next cycle equals the reset values. A pending suspend is dropped.
- RST_PLL: pll_reset=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK: pll_reset=0, usb_rst=1.
  - If lock_s=1, go to STABLE.
  - Else, when cnt==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRY, go to FAIL; otherwise increment retry_cnt and go to RST_PLL.
- STABLE: requires lock_s=1 on every cycle.
  - Any lock_s=0 returns to WAIT_LOCK with a fresh timeout. retry_cnt is unchanged.
  - After STABLE_CYCLES cycles, go to RUN.
- RUN: usb_rst=0, pll_ready=1.
  - Latency: pll_ready and usb_rst switch STABLE_CYCLES+3 clkin edges after lock rises (2 synchroniser + STABLE_CYCLES + 1 transition).
- RUN, lock_s=0: go to RST_PLL. In the same transition, increment loss_cnt (saturating at 255) and clear retry_cnt. The next cycle shows usb_rst=1, pll_ready=0, pll_reset=1.
- RUN, suspend_req=1 with lock_s=1: go to SUSP. Lock loss has priority when both occur in the same cycle.
- SUSP: pll_pwd=1, suspend_ack=1, usb_rst=1, pll_ready=0, pll_reset=0.
  - lock_s is ignored; loss_cnt does not change.
  - When suspend_req=0: clear retry_cnt and go to RST_PLL. suspend_ack and pll_pwd drop the next cycle.
- suspend_req outside RUN/SUSP is ignored; it is honoured once RUN is reached.
- FAIL: fail=1, pll_reset=1, usb_rst=1, pll_ready=0, retry_cnt held. Exit only via reset.
- Counter widths: cnt saturates. Parameters must satisfy RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT ≤ 65535 and ≥1.

Test Plan:
Use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2 unless noted.
1. Release reset; raise lock 10 cycles after pll_reset falls → pll_reset high exactly 4 cycles; pll_ready=1 and usb_rst=0 exactly 11 edges after lock rises; retry_cnt=0.
2. Lock high 5 cycles, low 1, then high → no pll_ready at the 8-cycle mark; STABLE restarts; pll_ready arrives 11 edges after the second rise; retry_cnt=0, no extra pll_reset pulse.
3. lock held 0 → three 4-cycle pll_reset pulses, 20 cycles apart in WAIT_LOCK; retry_cnt goes 1 then 2; fail=1 after the third timeout (72 cycles after reset release); a later lock rise has no effect until reset.
4. In RUN, drop lock → 3 edges later usb_rst=1, pll_ready=0, pll_reset=1 for 4 cycles, loss_cnt=1; re-raise lock → RUN again, loss_cnt stays 1.
5. In RUN, assert suspend_req, then drop lock → pll_pwd=1, suspend_ack=1, loss_cnt unchanged. Deassert suspend_req → ack/pwd fall next cycle, 4-cycle pll_reset, relock reaches RUN.
6. Force 256 loss/relock cycles → loss_cnt saturates at 255. Drop lock and assert suspend_req in the same cycle → RST_PLL taken, not SUSP. Assert reset during SUSP → pll_pwd=0 next cycle.

Source files
------------

// File: rtl/usb_pll_ctrl.sv
// usb_pll_ctrl: power-up and lock supervisor for the USB clock PLL.
// Drives PLL RESET/PLLPWD, qualifies LOCK, retries and recovers from lock loss.
module usb_pll_ctrl #(
   parameter int RST_CYCLES    = 24,
   parameter int LOCK_TIMEOUT  = 24000,
   parameter int STABLE_CYCLES = 240,
   parameter int MAX_RETRY     = 3
) (
   input  logic       clkin,
   input  logic       reset,
   input  logic       lock,
   input  logic       suspend_req,
   output logic       pll_reset,
   output logic       pll_pwd,
   output logic       usb_rst,
   output logic       pll_ready,
   output logic       suspend_ack,
   output logic       fail,
   output logic [2:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   typedef enum logic [2:0] {
      RST_PLL,
      WAIT_LOCK,
      STABLE,
      RUN,
      SUSP,
      FAIL
   } state_t;

   localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
   localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] STAB_LAST = 16'(STABLE_CYCLES - 1);
   localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);

   state_t      state;
   state_t      nxt;
   logic [15:0] cnt;
   logic        lock_m;
   logic        lock_s;
   logic [2:0]  retry_n;
   logic [7:0]  loss_n;

   // Bring the asynchronous LOCK pin into the clkin domain.
   always_ff @(posedge clkin) begin
      if (reset) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= lock;
         lock_s <= lock_m;
      end
   end

   // Next-state and retry/loss bookkeeping for the acquisition sequence.
   always_comb begin
      nxt     = state;
      retry_n = retry_cnt;
      loss_n  = loss_cnt;
      unique case (state)
         RST_PLL: begin
            if (cnt == RST_LAST) nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               nxt = STABLE;
            end else if (cnt == LOCK_LAST) begin
               if (retry_cnt == RETRY_MAX) begin
                  nxt = FAIL;
               end else begin
                  retry_n = retry_cnt + 3'd1;
                  nxt     = RST_PLL;
               end
            end
         end
         STABLE: begin
            if (!lock_s) nxt = WAIT_LOCK;
            else if (cnt == STAB_LAST) nxt = RUN;
         end
         RUN: begin
            if (!lock_s) begin
               nxt     = RST_PLL;
               retry_n = 3'd0;
               if (loss_cnt != 8'hFF) loss_n = loss_cnt + 8'd1;
            end else if (suspend_req) begin
               nxt = SUSP;
            end
         end
         SUSP: begin
            if (!suspend_req) begin
               nxt     = RST_PLL;
               retry_n = 3'd0;
            end
         end
         FAIL: begin
            nxt = FAIL;
         end
         default: begin
            nxt = RST_PLL;
         end
      endcase
   end

   // State, dwell counter and Moore outputs decoded from the next state.
   always_ff @(posedge clkin) begin
      if (reset) begin
         state       <= RST_PLL;
         cnt         <= 16'd0;
         pll_reset   <= 1'b1;
         pll_pwd     <= 1'b0;
         usb_rst     <= 1'b1;
         pll_ready   <= 1'b0;
         suspend_ack <= 1'b0;
         fail        <= 1'b0;
         retry_cnt   <= 3'd0;
         loss_cnt    <= 8'd0;
      end else begin
         state <= nxt;
         if (nxt != state) cnt <= 16'd0;
         else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
         retry_cnt   <= retry_n;
         loss_cnt    <= loss_n;
         pll_reset   <= (nxt == RST_PLL) || (nxt == FAIL);
         pll_pwd     <= (nxt == SUSP);
         usb_rst     <= (nxt != RUN);
         pll_ready   <= (nxt == RUN);
         suspend_ack <= (nxt == SUSP);
         fail        <= (nxt == FAIL);
      end
   end

endmodule

// File: tb/tb_usb_pll_ctrl.sv
// tb_usb_pll_ctrl: directed scenarios plus randomized lock/suspend/reset
// traffic, checked every cycle against a dwell-time model of the supervisor.
module tb_usb_pll_ctrl;

   localparam int RC = 4;
   localparam int LT = 20;
   localparam int SC = 8;
   localparam int MR = 2;

   localparam int P_RST  = 0;
   localparam int P_WAIT = 1;
   localparam int P_STAB = 2;
   localparam int P_RUN  = 3;
   localparam int P_SUSP = 4;
   localparam int P_FAIL = 5;

   logic       clkin = 1'b0;
   logic       reset;
   logic       lock;
   logic       suspend_req;
   logic       pll_reset;
   logic       pll_pwd;
   logic       usb_rst;
   logic       pll_ready;
   logic       suspend_ack;
   logic       fail;
   logic [2:0] retry_cnt;
   logic [7:0] loss_cnt;

   int total = 0;
   int bad   = 0;

   int ph      = P_RST;
   int dwell   = 0;
   int m_retry = 0;
   int m_loss  = 0;
   bit armed   = 1'b0;
   bit lq[$];

   always #5 clkin = ~clkin;

   usb_pll_ctrl #(
      .RST_CYCLES(RC),
      .LOCK_TIMEOUT(LT),
      .STABLE_CYCLES(SC),
      .MAX_RETRY(MR)
   ) dut (
      .clkin(clkin),
      .reset(reset),
      .lock(lock),
      .suspend_req(suspend_req),
      .pll_reset(pll_reset),
      .pll_pwd(pll_pwd),
      .usb_rst(usb_rst),
      .pll_ready(pll_ready),
      .suspend_ack(suspend_ack),
      .fail(fail),
      .retry_cnt(retry_cnt),
      .loss_cnt(loss_cnt)
   );

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic go(input int p);
      ph    = p;
      dwell = 0;
   endtask

   function automatic logic [16:0] want_vec();
      logic [16:0] v;
      v = {ph == P_RST || ph == P_FAIL, ph == P_SUSP, ph != P_RUN,
           ph == P_RUN, ph == P_SUSP, ph == P_FAIL,
           3'(m_retry), 8'(m_loss)};
      return v;
   endfunction

   // Reference model: each phase ends after a fixed number of edges or on
   // the two-edge-delayed lock value / suspend level.
   always @(posedge clkin) begin
      bit ls;
      if (reset) begin
         lq.delete();
         lq.push_back(1'b0);
         lq.push_back(1'b0);
         go(P_RST);
         m_retry = 0;
         m_loss  = 0;
         armed   = 1'b1;
      end else if (armed) begin
         ls = lq.pop_front();
         lq.push_back(lock);
         dwell++;
         case (ph)
            P_RST: if (dwell == RC) go(P_WAIT);
            P_WAIT: begin
               if (ls) go(P_STAB);
               else if (dwell == LT) begin
                  if (m_retry == MR) go(P_FAIL);
                  else begin
                     m_retry++;
                     go(P_RST);
                  end
               end
            end
            P_STAB: begin
               if (!ls) go(P_WAIT);
               else if (dwell == SC) go(P_RUN);
            end
            P_RUN: begin
               if (!ls) begin
                  m_loss  = (m_loss < 255) ? m_loss + 1 : 255;
                  m_retry = 0;
                  go(P_RST);
               end else if (suspend_req) go(P_SUSP);
            end
            P_SUSP: begin
               if (!suspend_req) begin
                  m_retry = 0;
                  go(P_RST);
               end
            end
            default: ;
         endcase
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clkin) begin
      logic [16:0] got;
      if (armed) begin
         got = {pll_reset, pll_pwd, usb_rst, pll_ready, suspend_ack, fail,
                retry_cnt, loss_cnt};
         total++;
         if (got !== want_vec()) begin
            bad++;
            $display("FAIL cycle t=%0t got=%h want=%h", $time, got, want_vec());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clkin);
   endtask

   task automatic do_reset();
      @(negedge clkin);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic wait_ready();
      int k;
      k = 0;
      while (!pll_ready && k < 200) begin
         @(negedge clkin);
         k++;
      end
      if (k >= 200) chk("ready_timeout", 0, 1);
   endtask

   task automatic wait_not_ready();
      int k;
      k = 0;
      while (pll_ready && k < 50) begin
         @(negedge clkin);
         k++;
      end
      if (k >= 50) chk("drop_timeout", 0, 1);
   endtask

   task automatic edges_to_ready(input string nm, input int exp);
      int k;
      k = 0;
      do begin
         @(posedge clkin);
         #1;
         k++;
      end while (!pll_ready && k < 100);
      chk(nm, k, exp);
      @(negedge clkin);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int prev;
      reset       = 1'b1;
      lock        = 1'b0;
      suspend_req = 1'b0;
      tick(3);
      chk("reset_state",
          int'({pll_reset, pll_pwd, usb_rst, pll_ready, suspend_ack, fail,
                retry_cnt, loss_cnt}),
          int'(17'b1_0_1_0_0_0_000_00000000));

      // Clean acquisition
      reset = 1'b0;
      n = 0;
      while (pll_reset && n < 50) begin
         n++;
         @(negedge clkin);
      end
      chk("rst_width", n, RC);
      tick(10);
      lock = 1'b1;
      edges_to_ready("lock_to_ready", SC + 3);
      chk("run_usb_rst", int'(usb_rst), 0);
      chk("run_retry", int'(retry_cnt), 0);

      // Lock glitch during qualification
      do_reset();
      lock = 1'b0;
      n = 0;
      while (pll_reset && n < 50) begin
         n++;
         @(negedge clkin);
      end
      tick(2);
      lock = 1'b1;
      tick(5);
      lock = 1'b0;
      tick(1);
      lock = 1'b1;
      edges_to_ready("glitch_to_ready", SC + 3);
      chk("glitch_retry", int'(retry_cnt), 0);

      // No lock at all: retries then give up
      do_reset();
      lock = 1'b0;
      n = 0;
      while (!fail && n < 200) begin
         @(posedge clkin);
         #1;
         n++;
      end
      chk("fail_time", n, 3 * RC + 3 * LT);
      chk("fail_retry", int'(retry_cnt), MR);
      @(negedge clkin);
      lock = 1'b1;
      tick(30);
      chk("fail_hold", int'(fail), 1);
      chk("fail_no_ready", int'(pll_ready), 0);

      // Loss of lock in RUN
      do_reset();
      lock = 1'b1;
      wait_ready();
      lock = 1'b0;
      n = 0;
      while (pll_ready && n < 20) begin
         @(posedge clkin);
         #1;
         n++;
      end
      chk("loss_latency", n, 3);
      chk("loss_pll_reset", int'(pll_reset), 1);
      chk("loss_usb_rst", int'(usb_rst), 1);
      chk("loss_count", int'(loss_cnt), 1);
      @(negedge clkin);
      lock = 1'b1;
      wait_ready();
      chk("relock_loss", int'(loss_cnt), 1);

      // Suspend handshake
      suspend_req = 1'b1;
      tick(3);
      chk("susp_ack", int'(suspend_ack), 1);
      chk("susp_pwd", int'(pll_pwd), 1);
      lock = 1'b0;
      tick(5);
      chk("susp_loss", int'(loss_cnt), 1);
      chk("susp_ack_hold", int'(suspend_ack), 1);
      suspend_req = 1'b0;
      @(posedge clkin);
      #1;
      chk("resume_ack", int'(suspend_ack), 0);
      chk("resume_pwd", int'(pll_pwd), 0);
      chk("resume_rst", int'(pll_reset), 1);
      @(negedge clkin);
      lock = 1'b1;
      wait_ready();
      chk("resume_ready", int'(pll_ready), 1);

      // Loss counter saturation
      do_reset();
      for (int i = 0; i < 256; i++) begin
         lock = 1'b1;
         wait_ready();
         lock = 1'b0;
         wait_not_ready();
      end
      chk("loss_sat", int'(loss_cnt), 255);

      // Lock loss wins over a simultaneous suspend request
      lock = 1'b1;
      wait_ready();
      lock = 1'b0;
      tick(2);
      suspend_req = 1'b1;
      @(posedge clkin);
      #1;
      chk("prio_rst", int'(pll_reset), 1);
      chk("prio_ack", int'(suspend_ack), 0);
      @(negedge clkin);
      tick(3);
      chk("prio_ack_late", int'(suspend_ack), 0);
      suspend_req = 1'b0;
      lock = 1'b1;
      wait_ready();

      // Reset during suspend
      prev = int'(loss_cnt);
      chk("pre_susp_loss", prev, 255);
      suspend_req = 1'b1;
      tick(3);
      reset = 1'b1;
      @(posedge clkin);
      #1;
      chk("rst_susp_pwd", int'(pll_pwd), 0);
      chk("rst_susp_ack", int'(suspend_ack), 0);
      chk("rst_susp_loss", int'(loss_cnt), 0);
      @(negedge clkin);
      reset = 1'b0;
      tick(20);
      suspend_req = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         @(negedge clkin);
         if (lock) begin
            if ($urandom_range(0, 29) == 0) lock = 1'b0;
         end else begin
            if ($urandom_range(0, 14) == 0) lock = 1'b1;
         end
         if ($urandom_range(0, 39) == 0) suspend_req = ~suspend_req;
         reset = ($urandom_range(0, 599) == 0);
      end

      @(negedge clkin);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
